rr_burst_arb_4: RTL and testbench
=================================

// Module: rr_burst_arb_4
// PURPOSE
//  Round-robin arbiter sharing one W-bit output channel among 4 requesters.
//  Grants whole bursts, not single beats: once a source wins, it holds the channel until its req_last beat is accepted.
//  Steers a 4:1 data mux, with sel = grant index, into a registered output stage.
//  Sits between 4 producer streams and one downstream consumer with a valid/ready interface.
// PARAMETERS
//  W      4   data width per requester, in bits; legal for any W >= 1
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  req_valid  in   4     per-source beat valid
//  req_last   in   4     per-source last-beat-of-burst flag; only sampled with valid
//  req_data   in   4*W   source i occupies bits [i*W +: W]
//  req_ready  out  4     per-source accept (combinational); at most one bit high
//  out_valid  out  1     registered output beat valid
//  out_data   out  W     registered output data
//  out_last   out  1     registered copy of the accepted req_last
//  out_sel    out  2     index of the source that produced the current out beat
//  out_ready  in   1     downstream accept
//  busy       out  1     high while in BURST state
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   state=IDLE, ptr=0, lock=0, out_valid=0, out_data=0, out_last=0, out_sel=0.
//   Any in-flight burst is discarded; no beat is replayed.
//  Slot availability:
//   slot_free = !out_valid || out_ready.
//   xfer = |(req_valid & req_ready).
//  Winner selection in IDLE:
//   g = first i with req_valid[i], scanning ptr, ptr+1, ..., ptr+3 (mod 4).
//   req_ready[g] = slot_free; all other req_ready bits = 0.
//  IDLE transitions on xfer:
//   if req_last[g]: stay IDLE, ptr <= g+1 (mod 4), so 3 wraps to 0.
//   else: go to BURST, lock <= g.
//  BURST:
//   req_ready[lock] = slot_free; all other sources are blocked, even when valid.
//   on xfer with req_last[lock]: go to IDLE, ptr <= lock+1 (mod 4).
//   If the locked source deasserts valid mid-burst, the lock is held indefinitely; there is no timeout.
//  Output register:
//   on xfer: out_valid<=1, out_data<=req_data[src], out_last<=req_last[src], out_sel<=src.
//   else if out_ready: out_valid<=0; data, last and sel hold their values.
//   out_data, out_last and out_sel are stable while out_valid && !out_ready.
//  Timing:
//   Latency is 1 cycle from input handshake to out_valid.
//   Full throughput: 1 beat/cycle when out_ready is held high, including back-to-back bursts from different sources.
//   Switching sources costs no idle cycle.
//  Combinational paths:
//   req_ready depends combinationally on out_ready and req_valid.
//   No path runs from req_* to out_* without passing through a register.
//  Single-beat burst: req_valid with req_last=1 in IDLE is granted and completed in one cycle; the FSM never enters BURST.
//  busy = (state==BURST).
// STRUCTURE
//  Package rr_arb_pkg:
//   typedef enum logic {IDLE, BURST} arb_state_t;
//   localparam N_REQ = 4;
//   typedef logic [1:0] src_idx_t.
//  Sub-module rr_pick_4: combinational rotating-priority picker.
//   inputs: req[3:0], ptr[1:0].
//   outputs: any, idx[1:0].
//  Top level holds the FSM, ptr/lock registers, the W-bit 4:1 data mux indexed by the active source, and the output register.
// TESTING
//  1) Reset: rst_n=0 mid-burst with out_valid=1 -> all outputs 0 immediately (async); after release, state=IDLE and ptr=0.
//  2) Fairness: all 4 valid, every beat last, out_ready=1 held -> out_sel sequence 0,1,2,3,0,... one beat per cycle.
//  3) Burst lock: src1 sends 3 beats (last on beat 3) while src0 and src2 stay valid -> out_sel=1,1,1 then 2; req_ready[0] and req_ready[2] are 0 throughout the lock.
//  4) Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data, out_sel and out_last are frozen; req_ready=0; no beat is lost or duplicated.
//  5) Stall in burst: src3 drops valid after beat 1 of 2 while src0 is valid -> busy stays 1; src0 is not granted until src3 sends its last beat.
//  6) Wrap: ptr=3, only src0 and src3 valid with single beats -> grant 3 first, then 0; ptr wraps 3 -> 0 -> 1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin burst arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef logic [1:0] src_idx_t;

  // Round-robin successor; the 2-bit width makes 3 wrap to 0.
  function automatic src_idx_t next_idx(input src_idx_t i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker: returns the first asserted request
// found when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  src_idx_t         ptr,
  output logic             any,
  output src_idx_t         idx
);

  src_idx_t cand;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise an untaken path infers a latch.
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + src_idx_t'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arb_4.sv
// Round-robin arbiter that grants whole bursts from 4 producers onto one
// registered valid/ready output channel.
module rr_burst_arb_4
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic               out_last,
  output src_idx_t           out_sel,
  input  logic               out_ready,
  output logic               busy
);

  arb_state_t state;
  src_idx_t   ptr;
  src_idx_t   lock;

  logic       pick_any;
  src_idx_t   pick_idx;
  src_idx_t   src;
  logic       slot_free;
  logic       xfer;
  logic       src_last;
  logic [W-1:0] src_data;

  rr_pick_4 u_pick (
    .req (req_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The output register can take a beat when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  // Active source: the locked one mid-burst, otherwise this cycle's RR winner.
  always_comb begin
    src       = pick_idx;
    req_ready = '0;
    if (state == BURST) begin
      src             = lock;
      req_ready[lock] = slot_free;
    end else if (pick_any) begin
      req_ready[pick_idx] = slot_free;
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign src_last = req_last[src];
  assign src_data = req_data[int'(src)*W +: W];
  assign busy     = (state == BURST);

  // Arbitration FSM: single beats stay in IDLE, multi-beat bursts lock the source.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      lock  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (src_last) begin
              ptr <= next_idx(src);
            end else begin
              state <= BURST;
              lock  <= src;
            end
          end
        end
        BURST: begin
          if (xfer && src_last) begin
            state <= IDLE;
            ptr   <= next_idx(lock);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: capture accepted beats, clear valid when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= src_data;
      out_last  <= src_last;
      out_sel   <= src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_burst_arb_4.sv
// Directed bench for rr_burst_arb_4: per-source beat queues drive the inputs,
// hand-ordered expected beats go into a scoreboard that a monitor drains.
module tb_rr_burst_arb_4;
  import rr_arb_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  typedef struct packed {
    src_idx_t     sel;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_last;
  src_idx_t           out_sel;
  logic               out_ready;
  logic               busy;

  beat_t src_q[N_REQ][$];
  exp_t  exp_q[$];
  exp_t  mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_burst_arb_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source driver: pop beats that handshook last cycle, present queue heads.
  initial begin
    logic [N_REQ-1:0] fire;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      fire = rst_n ? (req_valid & req_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]        = 1'b1;
          req_last[i]         = src_q[i][0].last;
          req_data[i*W +: W]  = src_q[i][0].data;
        end else begin
          req_valid[i]        = 1'b0;
          req_last[i]         = 1'b0;
          req_data[i*W +: W]  = '0;
        end
      end
    end
  end

  // Monitor: every accepted output beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {30'd0, out_sel}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_sel",  {30'd0, out_sel},  {30'd0, mon_e.sel});
          check("beat_data", {28'd0, out_data}, {28'd0, mon_e.data});
          check("beat_last", {31'd0, out_last}, {31'd0, mon_e.last});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int s, input int k, input bit last);
    beat_t b;
    b.last = last;
    b.data = {s[1:0], k[1:0]};
    src_q[s].push_back(b);
  endtask

  task automatic expect_beat(input int s, input int k, input bit last);
    exp_t e;
    e.sel  = s[1:0];
    e.data = {s[1:0], k[1:0]};
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int busy_cyc;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_out_sel",   {30'd0, out_sel},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    step();

    // Fairness: all four valid, every beat last, one beat per cycle
    for (int s = 0; s < N_REQ; s++) begin
      push(s, 0, 1'b1);
      push(s, 1, 1'b1);
    end
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N_REQ; s++) expect_beat(s, k, 1'b1);
    wait_out_valid("fair_first");
    for (int i = 0; i < 8; i++) begin
      check("fair_tput", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    wait_drain("fair_drain");

    // Burst lock: move ptr to 1, then src1 bursts 3 beats against src0/src2
    step();
    push(0, 0, 1'b1);
    expect_beat(0, 0, 1'b1);
    wait_drain("lock_pre_drain");
    step();
    push(1, 0, 1'b0);
    push(1, 1, 1'b0);
    push(1, 2, 1'b1);
    push(0, 1, 1'b1);
    push(2, 0, 1'b1);
    expect_beat(1, 0, 1'b0);
    expect_beat(1, 1, 1'b0);
    expect_beat(1, 2, 1'b1);
    expect_beat(2, 0, 1'b1);
    expect_beat(0, 1, 1'b1);
    busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        check("lock_blocked", {28'd0, req_ready & 4'b0101}, 32'd0);
      end
    end
    check("lock_len", busy_cyc, 32'd2);
    wait_drain("lock_drain");

    // Backpressure: ptr=1, output stalled for 5 cycles
    step();
    out_ready = 1'b0;
    push(1, 3, 1'b1);
    push(2, 1, 1'b1);
    expect_beat(1, 3, 1'b1);
    expect_beat(2, 1, 1'b1);
    wait_out_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_sel_hold",   {30'd0, out_sel},   32'd1);
      check("bp_data_hold",  {28'd0, out_data},  32'h7);
      check("bp_last_hold",  {31'd0, out_last},  32'd1);
      check("bp_no_ready",   {28'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Stall in burst: ptr=3, src3 goes idle after beat 1 of 2, src0 waits
    step();
    push(3, 0, 1'b0);
    push(0, 2, 1'b1);
    expect_beat(3, 0, 1'b0);
    expect_beat(3, 1, 1'b1);
    expect_beat(0, 2, 1'b1);
    wait_busy("stall_busy");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_busy_hold", {31'd0, busy},         32'd1);
      check("stall_src0_blk",  {31'd0, req_ready[0]}, 32'd0);
    end
    step();
    push(3, 1, 1'b1);
    wait_drain("stall_drain");

    // Wrap: ptr=1 -> single beat from src2 sets ptr=3; then 3 before 0
    step();
    push(2, 2, 1'b1);
    expect_beat(2, 2, 1'b1);
    wait_drain("wrap_pre_drain");
    step();
    push(0, 3, 1'b1);
    push(3, 2, 1'b1);
    expect_beat(3, 2, 1'b1);
    expect_beat(0, 3, 1'b1);
    wait_drain("wrap_drain");
    // ptr must now be 1: src1 beats src0
    step();
    push(0, 0, 1'b1);
    push(1, 1, 1'b1);
    expect_beat(1, 1, 1'b1);
    expect_beat(0, 0, 1'b1);
    wait_drain("wrap_ptr1_drain");

    // Reset mid-burst: ptr=1, src2 locked with out_valid=1
    step();
    push(2, 0, 1'b0);
    push(2, 1, 1'b0);
    push(2, 2, 1'b1);
    expect_beat(2, 0, 1'b0);
    expect_beat(2, 1, 1'b0);
    expect_beat(2, 2, 1'b1);
    wait_busy("rst_mid_busy");
    step();
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_data",  {28'd0, out_data},  32'd0);
    check("rst_async_last",  {31'd0, out_last},  32'd0);
    check("rst_async_sel",   {30'd0, out_sel},   32'd0);
    check("rst_async_busy",  {31'd0, busy},      32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    // After reset ptr=0: src0 wins over src3, no replay of the discarded burst
    push(3, 3, 1'b1);
    push(0, 1, 1'b1);
    expect_beat(0, 1, 1'b1);
    expect_beat(3, 3, 1'b1);
    wait_drain("post_rst_drain");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a wedged design still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
